// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: APCPU front end.
// Single-outstanding program-memory fetch, 2-entry prefetch FIFO, issue register.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     BUBBLE   = 32'h000000FF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FLUSH
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [1:0]        cnt_q;
  logic [31:0]       w0_q, w1_q;
  logic [ADDR_W-1:0] a0_q, a1_q;
  logic [31:0]       out_q;
  logic              vld_q;
  logic [ADDR_W-1:0] ipc_q;

  logic pop;
  logic room;
  logic take;
  logic push;
  logic widx;
  logic [1:0] cnt_d;

  // Pop/push qualifiers and the request decision for this cycle.
  always_comb begin
    pop  = !stall && !jump_en && (cnt_q != 2'd0);
    room = (cnt_q != 2'd2) || pop;
    mem_req  = !rst && ((state_q != S_REQ) || room);
    mem_addr = (state_q == S_REQ) ? pc_q : raddr_q;
    take = mem_req && mem_ack;
    push = take && !jump_en && (state_q != S_FLUSH);
    widx = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop);
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Fetch FSM: request tracking, fetch PC and redirect handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      raddr_q <= RESET_PC;
    end else begin
      if (state_q == S_REQ && mem_req && !mem_ack)
        raddr_q <= pc_q;
      if (jump_en) begin
        pc_q    <= jump_addr;
        state_q <= (mem_req && !mem_ack) ? S_FLUSH : S_REQ;
      end else if (take) begin
        state_q <= S_REQ;
        if (push)
          pc_q <= pc_q + 1'b1;
      end else if (mem_req && state_q == S_REQ) begin
        state_q <= S_WAIT;
      end
    end
  end

  // Prefetch FIFO: entry 0 is the head, shifted on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      w0_q  <= '0;
      w1_q  <= '0;
      a0_q  <= '0;
      a1_q  <= '0;
    end else if (jump_en) begin
      cnt_q <= 2'd0;
    end else begin
      if (pop) begin
        w0_q <= w1_q;
        a0_q <= a1_q;
      end
      if (push) begin
        if (widx) begin
          w1_q <= mem_rdata;
          a1_q <= mem_addr;
        end else begin
          w0_q <= mem_rdata;
          a0_q <= mem_addr;
        end
      end
      cnt_q <= cnt_d;
    end
  end

  // Issue register toward the decoder; jump beats stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= BUBBLE;
      vld_q <= 1'b0;
      ipc_q <= '0;
    end else if (jump_en) begin
      out_q <= BUBBLE;
      vld_q <= 1'b0;
    end else if (!stall) begin
      if (cnt_q != 2'd0) begin
        out_q <= w0_q;
        ipc_q <= a0_q;
        vld_q <= 1'b1;
      end else begin
        out_q <= BUBBLE;
        vld_q <= 1'b0;
      end
    end
  end

  assign instr_out   = out_q;
  assign instr_valid = vld_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed + random stimulus
// against a queue-based reference of the fetch unit.
module tb_instr_fetch_unit;

  localparam logic [31:0] BUB = 32'h000000FF;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [15:0] instr_pc;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .instr_pc   (instr_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [47:0] q[$];
  logic        m_busy, m_bad;
  logic [15:0] m_oaddr, m_pc;
  logic [31:0] m_out;
  logic        m_vld;
  logic [15:0] m_ipc;

  int fixdly = 0;
  int wcnt = 0;
  int cdly = 0;
  bit spur = 0;

  function automatic logic [31:0] memw(input logic [15:0] a);
    return {8'h00, a, 8'h03};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    q.delete();
    m_busy = 0; m_bad = 0;
    m_oaddr = 16'h0; m_pc = 16'h0;
    m_out = BUB; m_vld = 0; m_ipc = 16'h0;
    wcnt = 0;
  endtask

  task automatic chk_out();
    chk("instr_out", instr_out, m_out);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_vld});
    chk("instr_pc", {16'b0, instr_pc}, {16'b0, m_ipc});
  endtask

  // Entered at posedge+1 with stall/jump already driven.
  task automatic step();
    logic p_pop, p_req, acc;
    logic [15:0] p_addr;
    logic [47:0] e;
    #1;
    p_pop  = !stall && !jump_en && (q.size() > 0);
    p_req  = m_busy || ((q.size() - int'(p_pop)) < 2);
    p_addr = m_busy ? m_oaddr : m_pc;
    chk("mem_req", {31'b0, mem_req}, {31'b0, p_req});
    if (p_req) chk("mem_addr", {16'b0, mem_addr}, {16'b0, p_addr});
    chk_out();
    if (p_req) begin
      if (wcnt == 0)
        cdly = (fixdly >= 0) ? fixdly : int'($urandom_range(0, 3));
      if (wcnt >= cdly) begin
        mem_ack = 1'b1; mem_rdata = memw(p_addr); wcnt = 0;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom; wcnt++;
      end
    end else begin
      mem_ack = spur && ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
    end
    @(posedge clk);
    acc = p_req && mem_ack;
    if (jump_en) begin
      q.delete();
      m_out = BUB; m_vld = 0;
      if (p_req && !mem_ack) begin
        m_oaddr = p_addr; m_busy = 1; m_bad = 1;
      end else begin
        m_busy = 0; m_bad = 0;
      end
      m_pc = jump_addr;
    end else begin
      if (!stall) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          m_out = e[47:16]; m_ipc = e[15:0]; m_vld = 1;
        end else begin
          m_out = BUB; m_vld = 0;
        end
      end
      if (acc) begin
        if (!m_bad) begin
          q.push_back({mem_rdata, p_addr});
          m_pc = m_pc + 16'd1;
        end
        m_busy = 0; m_bad = 0;
      end else if (p_req) begin
        m_oaddr = p_addr; m_busy = 1;
      end
    end
    #1;
  endtask

  task automatic chk_rst();
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_out", instr_out, BUB);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc", {16'b0, instr_pc}, 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_addr = 16'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    mreset();
    #2 chk_rst();
    @(posedge clk); #1 rst = 1'b0;

    // zero-wait fetch after reset
    fixdly = 0;
    step(); step();
    chk("first_instr", instr_out, 32'h00000003);
    chk("first_valid", {31'b0, instr_valid}, 32'd1);
    step();
    chk("second_instr", instr_out, 32'h00000103);
    repeat (4) step();

    // slow memory
    fixdly = 3;
    repeat (14) step();

    // stall with zero-wait memory
    fixdly = 0;
    stall = 1'b1;
    repeat (5) step();
    #1 chk("stall_req_drop", {31'b0, mem_req}, 32'd0);
    stall = 1'b0;
    repeat (4) step();

    // jump while a request is outstanding
    fixdly = 2;
    k = 0;
    while (!m_busy && k < 20) begin step(); k++; end
    chk("busy_seen", {31'b0, m_busy}, 32'd1);
    jump_en = 1'b1; jump_addr = 16'h0040;
    step();
    jump_en = 1'b0;
    k = 0;
    while (!instr_valid && k < 20) begin step(); k++; end
    chk("jump_valid_seen", {31'b0, instr_valid}, 32'd1);
    chk("jump_first_pc", {16'b0, instr_pc}, 32'h0040);

    // jump coincident with zero-wait ack, then under stall
    fixdly = 0;
    repeat (2) step();
    jump_en = 1'b1; jump_addr = 16'h0100;
    step();
    jump_en = 1'b0;
    repeat (3) step();
    stall = 1'b1; jump_en = 1'b1; jump_addr = 16'h0200;
    step();
    jump_en = 1'b0;
    step();
    stall = 1'b0;
    repeat (3) step();

    // fetch PC wrap
    jump_en = 1'b1; jump_addr = 16'hFFFE;
    step();
    jump_en = 1'b0;
    repeat (6) step();

    // randomized traffic
    fixdly = -1; spur = 1;
    repeat (400) begin
      stall = ($urandom_range(0, 3) == 0);
      jump_en = ($urandom_range(0, 11) == 0);
      jump_addr = ($urandom_range(0, 3) == 0) ?
                  16'hFFFC + 16'($urandom_range(0, 3)) :
                  16'($urandom);
      step();
    end
    stall = 1'b0; jump_en = 1'b0; spur = 0;

    // reset asserted mid-wait
    fixdly = 10;
    k = 0;
    while (!m_busy && k < 20) begin step(); k++; end
    chk("wait_seen", {31'b0, m_busy}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_rst();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1 chk_rst();
    mem_ack = 1'b0;
    rst = 1'b0;
    mreset();
    fixdly = 0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
